// File: rtl/holo_fetch_unit.sv
// Byte-serial instruction fetch: assembles four little-endian bytes into a command word.
// Optional misaligned-redirect trap enabled by defining FETCH_MISALIGN_TRAP_EN.
module holo_fetch_unit #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter bit          HOLD_CE  = 1'b0
) (
  input  logic        clk,
  input  logic        rst,
  output logic [31:0] instr_addr,
  input  logic [7:0]  instr_in,
  output logic        instr_ce,
  output logic        instr_oe,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_pc,
  output logic [31:0] cmd,
  output logic [31:0] cmd_pc,
  output logic        cmd_valid,
  input  logic        cmd_ready,
  output logic        fetch_fault
);

  typedef enum logic [1:0] {
    S_FETCH = 2'd0,
    S_HOLD  = 2'd1,
    S_FAULT = 2'd2
  } state_t;

  state_t      state_q, state_d;
  logic [31:0] pc_q, pc_d;
  logic [31:0] addr_q, addr_d;
  logic [1:0]  byte_idx_q, byte_idx_d;
  logic [31:0] cmd_q, cmd_d;
  logic [31:0] cmd_pc_q, cmd_pc_d;
  logic        cmd_valid_q, cmd_valid_d;
  logic [31:0] redir_pc;
  logic        misalign;
  logic        mem_en;

  // Low bits are masked off so an unaligned target can never reach memory.
  assign redir_pc = redirect_pc & ~32'h0000_0003;

`ifdef FETCH_MISALIGN_TRAP_EN
  logic fault_q, fault_d;
  assign misalign    = (redirect_pc[1:0] != 2'b00);
  assign fetch_fault = fault_q;
`else
  assign misalign    = 1'b0;
  assign fetch_fault = 1'b0;
`endif

  always_comb begin
    state_d     = state_q;
    pc_d        = pc_q;
    addr_d      = addr_q;
    byte_idx_d  = byte_idx_q;
    cmd_d       = cmd_q;
    cmd_pc_d    = cmd_pc_q;
    cmd_valid_d = cmd_valid_q;
`ifdef FETCH_MISALIGN_TRAP_EN
    fault_d     = fault_q;
`endif
    if (redirect_valid) begin
      byte_idx_d  = 2'd0;
      cmd_valid_d = 1'b0;
      if (misalign) begin
        state_d = S_FAULT;
`ifdef FETCH_MISALIGN_TRAP_EN
        fault_d = 1'b1;
`endif
      end else begin
        state_d = S_FETCH;
        pc_d    = redir_pc;
        addr_d  = redir_pc;
`ifdef FETCH_MISALIGN_TRAP_EN
        fault_d = 1'b0;
`endif
      end
    end else begin
      case (state_q)
        S_FETCH: begin
          case (byte_idx_q)
            2'd0:    cmd_d[7:0]   = instr_in;
            2'd1:    cmd_d[15:8]  = instr_in;
            2'd2:    cmd_d[23:16] = instr_in;
            default: cmd_d[31:24] = instr_in;
          endcase
          if (byte_idx_q == 2'd3) begin
            cmd_pc_d    = pc_q;
            cmd_valid_d = 1'b1;
            byte_idx_d  = 2'd0;
            state_d     = S_HOLD;
          end else begin
            addr_d     = addr_q + 32'd1;
            byte_idx_d = byte_idx_q + 2'd1;
          end
        end
        S_HOLD: begin
          if (cmd_ready) begin
            cmd_valid_d = 1'b0;
            pc_d        = pc_q + 32'd4;
            addr_d      = pc_q + 32'd4;
            state_d     = S_FETCH;
          end
        end
        default: ;
      endcase
    end
  end

  always_comb begin
    case (state_q)
      S_FETCH: mem_en = 1'b1;
      S_HOLD:  mem_en = HOLD_CE;
      default: mem_en = 1'b0;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= S_FETCH;
      pc_q        <= RESET_PC;
      addr_q      <= RESET_PC;
      byte_idx_q  <= 2'd0;
      cmd_q       <= 32'd0;
      cmd_pc_q    <= 32'd0;
      cmd_valid_q <= 1'b0;
`ifdef FETCH_MISALIGN_TRAP_EN
      fault_q     <= 1'b0;
`endif
    end else begin
      state_q     <= state_d;
      pc_q        <= pc_d;
      addr_q      <= addr_d;
      byte_idx_q  <= byte_idx_d;
      cmd_q       <= cmd_d;
      cmd_pc_q    <= cmd_pc_d;
      cmd_valid_q <= cmd_valid_d;
`ifdef FETCH_MISALIGN_TRAP_EN
      fault_q     <= fault_d;
`endif
    end
  end

  assign instr_addr = addr_q;
  assign instr_ce   = mem_en;
  assign instr_oe   = mem_en;
  assign cmd        = cmd_q;
  assign cmd_pc     = cmd_pc_q;
  assign cmd_valid  = cmd_valid_q;

endmodule

// File: tb/tb_holo_fetch_unit.sv
// Scoreboard bench for holo_fetch_unit: directed fetch/redirect/reset vectors, monitor checks handshakes.
module tb_holo_fetch_unit;

  localparam bit HOLD_CE = 1'b0;

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] instr_addr;
  logic [7:0]  instr_in;
  logic        instr_ce, instr_oe;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic [31:0] cmd, cmd_pc;
  logic        cmd_valid;
  logic        cmd_ready;
  logic        fetch_fault;

  int total = 0;
  int bad   = 0;
  logic [63:0] exp_q[$];

  holo_fetch_unit #(.RESET_PC(32'h0000_0000), .HOLD_CE(HOLD_CE)) dut (
    .clk(clk), .rst(rst), .instr_addr(instr_addr), .instr_in(instr_in),
    .instr_ce(instr_ce), .instr_oe(instr_oe), .redirect_valid(redirect_valid),
    .redirect_pc(redirect_pc), .cmd(cmd), .cmd_pc(cmd_pc), .cmd_valid(cmd_valid),
    .cmd_ready(cmd_ready), .fetch_fault(fetch_fault)
  );

  always #5 clk = ~clk;

  // Memory contents: program word at 0, elsewhere byte = addr[7:0] ^ 0xA5.
  function automatic logic [7:0] mem_byte(input logic [31:0] a);
    case (a)
      32'h0: mem_byte = 8'h13;
      32'h1: mem_byte = 8'h05;
      32'h2: mem_byte = 8'hA0;
      32'h3: mem_byte = 8'h00;
      default: mem_byte = a[7:0] ^ 8'hA5;
    endcase
  endfunction

  // Registered address from the DUT, data valid within the following cycle.
  assign instr_in = mem_byte(instr_addr);

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic chk_reset_vals(input string tag);
    chk({tag, " addr"},  instr_addr, 32'h0);
    chk({tag, " valid"}, {31'd0, cmd_valid}, 32'd0);
    chk({tag, " cmd"},   cmd, 32'h0);
    chk({tag, " cmdpc"}, cmd_pc, 32'h0);
    chk({tag, " ce_oe"}, {30'd0, instr_ce, instr_oe}, 32'd3);
    chk({tag, " fault"}, {31'd0, fetch_fault}, 32'd0);
  endtask

  // Fetches one word with cmd_ready=1; the handshake edge is left to the caller.
  task automatic fetch_word(input string tag, input logic [31:0] pc, input logic [31:0] word);
    exp_q.push_back({word, pc});
    tick; chk({tag, " a1"}, instr_addr, pc + 32'd1);
    tick; chk({tag, " a2"}, instr_addr, pc + 32'd2);
    tick; chk({tag, " a3"}, instr_addr, pc + 32'd3);
    tick; chk({tag, " valid"}, {31'd0, cmd_valid}, 32'd1);
  endtask

  // Monitor: every accepted command is compared against the scoreboard.
  always @(negedge clk) begin
    if (!rst && cmd_valid && cmd_ready) begin
      if (exp_q.size() == 0) begin
        total++;
        bad++;
        $display("FAIL sb_underflow: got cmd %h pc %h with nothing expected", cmd, cmd_pc);
      end else begin
        logic [63:0] e;
        e = exp_q.pop_front();
        chk("sb cmd", cmd, e[63:32]);
        chk("sb cmd_pc", cmd_pc, e[31:0]);
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1; cmd_ready = 1'b0; redirect_valid = 1'b0; redirect_pc = 32'h0;
    tick; tick;
    chk_reset_vals("rst");
    rst = 1'b0;

    // First word with consumer stalled for 6 cycles
    tick; chk("t1 a1", instr_addr, 32'h1);
    tick; chk("t1 a2", instr_addr, 32'h2);
    tick; chk("t1 a3", instr_addr, 32'h3);
    tick; chk("t1 valid", {31'd0, cmd_valid}, 32'd1);
    chk("t1 cmd", cmd, 32'h00A0_0513);
    chk("t1 cmd_pc", cmd_pc, 32'h0);
    for (int i = 0; i < 6; i++) begin
      tick;
      chk("t2 hold cmd", cmd, 32'h00A0_0513);
      chk("t2 hold addr", instr_addr, 32'h3);
      chk("t2 hold valid", {31'd0, cmd_valid}, 32'd1);
      chk("t2 hold ce", {31'd0, instr_ce}, {31'd0, HOLD_CE});
    end
    exp_q.push_back({32'h00A0_0513, 32'h0});
    cmd_ready = 1'b1;
    tick;
    chk("t2 next addr", instr_addr, 32'h4);
    chk("t2 valid low", {31'd0, cmd_valid}, 32'd0);
    chk("t2 ce back", {31'd0, instr_ce}, 32'd1);

    fetch_word("w4", 32'h4, 32'hA2A3_A0A1);
    tick; chk("w4 next", instr_addr, 32'h8);

    // Redirect together with handshake at pc=8
    fetch_word("w8", 32'h8, 32'hAEAF_ACAD);
    redirect_valid = 1'b1; redirect_pc = 32'h100;
    tick; redirect_valid = 1'b0;
    chk("t4 addr", instr_addr, 32'h100);
    chk("t4 valid", {31'd0, cmd_valid}, 32'd0);

    // Redirect mid-word at byte_idx=2
    tick; tick; chk("t3 pre", instr_addr, 32'h102);
    redirect_valid = 1'b1; redirect_pc = 32'h40;
    tick; redirect_valid = 1'b0;
    chk("t3 addr", instr_addr, 32'h40);
    chk("t3 valid", {31'd0, cmd_valid}, 32'd0);
    fetch_word("w40", 32'h40, 32'hE6E7_E4E5);
    chk("t3 cmd", cmd, 32'hE6E7_E4E5);
    tick; chk("w40 next", instr_addr, 32'h44);

    // Wrap at top of address space
    redirect_valid = 1'b1; redirect_pc = 32'hFFFF_FFFC;
    tick; redirect_valid = 1'b0;
    chk("t5 addr", instr_addr, 32'hFFFF_FFFC);
    fetch_word("wtop", 32'hFFFF_FFFC, 32'h5A5B_5859);
    tick; chk("t5 wrap", instr_addr, 32'h0);

    // Asynchronous reset between edges at byte_idx=1
    tick; chk("t6 pre", instr_addr, 32'h1);
    #2 rst = 1'b1;
    #1 chk_reset_vals("async");
    tick; rst = 1'b0;
    fetch_word("w0b", 32'h0, 32'h00A0_0513);
    tick; chk("w0b next", instr_addr, 32'h4);

`ifdef FETCH_MISALIGN_TRAP_EN
    redirect_valid = 1'b1; redirect_pc = 32'h102;
    tick; redirect_valid = 1'b0;
    chk("f fault", {31'd0, fetch_fault}, 32'd1);
    chk("f ce_oe", {30'd0, instr_ce, instr_oe}, 32'd0);
    chk("f valid", {31'd0, cmd_valid}, 32'd0);
    tick; tick;
    chk("f addr frozen", instr_addr, 32'h4);
    chk("f still", {31'd0, fetch_fault}, 32'd1);
    redirect_valid = 1'b1; redirect_pc = 32'h103;
    tick;
    chk("f refault", {31'd0, fetch_fault}, 32'd1);
    redirect_pc = 32'h104;
    tick; redirect_valid = 1'b0;
    chk("f cleared", {31'd0, fetch_fault}, 32'd0);
    chk("f ce back", {31'd0, instr_ce}, 32'd1);
`else
    redirect_valid = 1'b1; redirect_pc = 32'h107;
    tick; redirect_valid = 1'b0;
    chk("m fault tied", {31'd0, fetch_fault}, 32'd0);
`endif
    chk("m addr", instr_addr, 32'h104);
    fetch_word("w104", 32'h104, 32'hA2A3_A0A1);
    tick; chk("w104 next", instr_addr, 32'h108);

    tick;
    chk("sb drained", exp_q.size(), 32'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
